// File: rtl/xbar_pkg.sv
// ---------------------------------------------------------------------------
// xbar_pkg
// Shared definitions for the crossbar output-port allocator:
//   - phit type codes carried in bits [3:2] of each input phit's top nibble
//   - allocator state enum (IDLE / BUSY)
//   - small one-hot / index conversion helpers
// ---------------------------------------------------------------------------
package xbar_pkg;

    localparam logic [1:0] TYPE_HEAD    = 2'b11;
    localparam logic [1:0] TYPE_PAYLOAD = 2'b10;

    localparam int N_IN = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic logic [N_IN-1:0] idx_to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Assumes at most one bit set; an all-zero input maps to index 0.
    function automatic logic [1:0] onehot_to_idx(input logic [N_IN-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_credit_allocator_if.sv
// ---------------------------------------------------------------------------
// rr_credit_allocator_if
// Bundles the per-output-port allocator signals.
//   i_this_port        : index of the output port this allocator serves
//   i_r0..i_r3         : top nibble of each input phit ([3:2] type, [1:0] route)
//   i_valid            : phit present per input
//   i_credit           : one downstream slot freed this cycle
//   o_select           : one-hot crossbar select (zero = no transfer)
//   o_shift            : discard upper route bits (head phits)
//   o_ready            : per-input consume strobe
//   o_valid            : phit driven downstream this cycle
//   o_credits          : current credit count
//   o_credit_err       : sticky credit-overflow flag
// master = the environment driving inputs, slave = the allocator.
// ---------------------------------------------------------------------------
interface rr_credit_allocator_if;
    logic [1:0] i_this_port;
    logic [3:0] i_r0;
    logic [3:0] i_r1;
    logic [3:0] i_r2;
    logic [3:0] i_r3;
    logic [3:0] i_valid;
    logic       i_credit;
    logic [3:0] o_select;
    logic       o_shift;
    logic [3:0] o_ready;
    logic       o_valid;
    logic [3:0] o_credits;
    logic       o_credit_err;

    modport master (
        output i_this_port, i_r0, i_r1, i_r2, i_r3, i_valid, i_credit,
        input  o_select, o_shift, o_ready, o_valid, o_credits, o_credit_err
    );

    modport slave (
        input  i_this_port, i_r0, i_r1, i_r2, i_r3, i_valid, i_credit,
        output o_select, o_shift, o_ready, o_valid, o_credits, o_credit_err
    );
endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Rotating-priority search over four requests. Starting at ptr_i, the first
// set request found walking ptr, ptr+1, ... (mod 4) is granted.
//   req_i : request vector
//   ptr_i : highest-priority index this cycle
//   gnt_o : one-hot grant (zero when no request)
// ---------------------------------------------------------------------------
module rr_arbiter
    import xbar_pkg::*;
(
    input  logic [N_IN-1:0] req_i,
    input  logic [1:0]      ptr_i,
    output logic [N_IN-1:0] gnt_o
);

    logic       found;
    logic [1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_IN; i++) begin
            // 2-bit wrap gives the modulo-4 walk for free.
            idx = ptr_i + 2'(i);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_credit_allocator.sv
// ---------------------------------------------------------------------------
// rr_credit_allocator
// Output-port allocator for a 4-input wormhole crossbar. Heads addressed to
// this port are arbitrated round-robin; the winner owns the port until its
// packet ends (owner phit valid and not PAYLOAD). Each forwarded phit consumes
// one downstream credit; transfers stall while no credit is available.
// Ports:
//   CREDITS : downstream buffer depth in phits (1..15)
//   i_clk   : clock, rising edge
//   i_rst   : synchronous active-high reset
//   bus     : rr_credit_allocator_if.slave (phits, valid, credit, selects)
// All outputs except o_credits/o_credit_err are combinational.
// ---------------------------------------------------------------------------
module rr_credit_allocator
    import xbar_pkg::*;
#(
    parameter int CREDITS = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    rr_credit_allocator_if.slave       bus
);

    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    state_e     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] credits_q, credits_d;
    logic       err_q, err_d;

    logic [3:0] phit [N_IN];
    logic [N_IN-1:0] req;
    logic [N_IN-1:0] gnt;
    logic [1:0] gnt_idx;
    logic [1:0] owner_type;
    logic       owner_vld;
    logic       port_free;
    logic       have_credit;
    logic       grant_en;
    logic       fwd_en;

    logic [3:0] select;
    logic       shift;
    logic [3:0] ready;
    logic       valid;

    assign phit[0] = bus.i_r0;
    assign phit[1] = bus.i_r1;
    assign phit[2] = bus.i_r2;
    assign phit[3] = bus.i_r3;

    always_comb begin
        for (int n = 0; n < N_IN; n++) begin
            req[n] = bus.i_valid[n] && (phit[n][3:2] == TYPE_HEAD)
                     && (phit[n][1:0] == bus.i_this_port);
        end
    end

    rr_arbiter u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    assign gnt_idx     = onehot_to_idx(gnt);
    assign owner_type  = phit[owner_q][3:2];
    assign owner_vld   = bus.i_valid[owner_q];
    assign have_credit = (credits_q != 4'd0);

    // A valid non-PAYLOAD phit on the owner marks the end of its packet, so
    // the port can be handed over in that very cycle.
    assign port_free = (state_q == IDLE) || (owner_vld && (owner_type != TYPE_PAYLOAD));
    assign grant_en  = !i_rst && port_free && have_credit && (|req);
    assign fwd_en    = !i_rst && (state_q == BUSY) && owner_vld
                       && (owner_type == TYPE_PAYLOAD) && have_credit;

    always_comb begin
        select = '0;
        shift  = 1'b0;
        ready  = '0;
        valid  = 1'b0;
        if (grant_en) begin
            select = gnt;
            shift  = 1'b1;
            ready  = gnt;
            valid  = 1'b1;
        end else if (fwd_en) begin
            select = idx_to_onehot(owner_q);
            ready  = idx_to_onehot(owner_q);
            valid  = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (grant_en) begin
            state_d = BUSY;
            owner_d = gnt_idx;
            ptr_d   = gnt_idx + 2'd1;
        end else if (port_free) begin
            state_d = IDLE;
        end
    end

    // Simultaneous consume and return cancel; a return while already full is
    // an upstream protocol error and is latched rather than wrapped.
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        if (valid && !bus.i_credit) begin
            credits_d = credits_q - 4'd1;
        end else if (bus.i_credit && !valid) begin
            if (credits_q == CRED_MAX) begin
                err_d = 1'b1;
            end else begin
                credits_d = credits_q + 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            credits_q <= CRED_MAX;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    assign bus.o_select     = select;
    assign bus.o_shift      = shift;
    assign bus.o_ready      = ready;
    assign bus.o_valid      = valid;
    assign bus.o_credits    = credits_q;
    assign bus.o_credit_err = err_q;

endmodule
